// File: rtl/match_flow_controller.sv
// -----------------------------------------------------------------------------
// match_flow_controller
//   Match-level sequencer that sits after the collision controller. It counts
//   points from the loss inputs and keeps the ball/paddle logic in reset
//   between rallies. It also runs the serve and point pauses, declares the
//   winner and raises sound requests.
//
// Ports
//   game_clk    in   game tick clock; all state changes on its rising edge
//   reset       in   asynchronous, active-high; clears everything
//   start_btn   in   rising edge starts a match from IDLE or OVER
//   lossA/lossB in   ball passed player A / B (the point goes to the other side)
//   wall_col    in   ball hit the floor or ceiling
//   paddle_col  in   ball hit a paddle
//   ball_reset  out  high = hold the collision controller in reset
//   points_a/b  out  match scores (3 bits)
//   state       out  IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4
//   game_over   out  high while in OVER
//   winner      out  0 = A, 1 = B; valid while game_over is high
//   beep        out  sound request
//   beep_tone   out  0 wall, 1 paddle, 2 point, 3 win
// -----------------------------------------------------------------------------
module match_flow_controller #(
   parameter int WIN_SCORE   = 5,
   parameter int SERVE_TICKS = 120,
   parameter int POINT_TICKS = 90,
   parameter int BEEP_TICKS  = 8
) (
   input  logic       game_clk,
   input  logic       reset,
   input  logic       start_btn,
   input  logic       lossA,
   input  logic       lossB,
   input  logic       wall_col,
   input  logic       paddle_col,
   output logic       ball_reset,
   output logic [2:0] points_a,
   output logic [2:0] points_b,
   output logic [2:0] state,
   output logic       game_over,
   output logic       winner,
   output logic       beep,
   output logic [1:0] beep_tone
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_PLAY  = 3'd2,
      S_POINT = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   localparam int BW = $clog2(BEEP_TICKS + 1);

   state_t        r_state;
   logic [7:0]    r_timer;
   logic [2:0]    r_points_a;
   logic [2:0]    r_points_b;
   logic          r_ball_reset;
   logic          r_game_over;
   logic          r_winner;
   logic [BW-1:0] r_beep_cnt;
   logic [1:0]    r_beep_tone;

   // Previous-cycle copies used for rising-edge detection
   logic r_start_q, r_lossa_q, r_lossb_q, r_wall_q, r_paddle_q;

   logic       w_start_ev, w_lossa_ev, w_lossb_ev, w_wall_ev, w_paddle_ev;
   logic [2:0] w_a_plus, w_b_plus;
   logic       w_in_play, w_to_over, w_to_point;

   assign w_start_ev  = start_btn  & ~r_start_q;
   assign w_lossa_ev  = lossA      & ~r_lossa_q;
   assign w_lossb_ev  = lossB      & ~r_lossb_q;
   assign w_wall_ev   = wall_col   & ~r_wall_q;
   assign w_paddle_ev = paddle_col & ~r_paddle_q;

   assign w_a_plus  = r_points_a + 3'd1;
   assign w_b_plus  = r_points_b + 3'd1;
   assign w_in_play = (r_state == S_PLAY);

   // Only a single-sided loss can end the match; a void rally always pauses
   assign w_to_over  = w_in_play &
                       ((w_lossa_ev & ~w_lossb_ev & (w_b_plus == 3'(WIN_SCORE))) |
                        (w_lossb_ev & ~w_lossa_ev & (w_a_plus == 3'(WIN_SCORE))));
   assign w_to_point = w_in_play & (w_lossa_ev | w_lossb_ev) & ~w_to_over;

   always_ff @(posedge game_clk or posedge reset) begin
      if (reset) begin
         r_start_q  <= 1'b0;
         r_lossa_q  <= 1'b0;
         r_lossb_q  <= 1'b0;
         r_wall_q   <= 1'b0;
         r_paddle_q <= 1'b0;
      end else begin
         r_start_q  <= start_btn;
         r_lossa_q  <= lossA;
         r_lossb_q  <= lossB;
         r_wall_q   <= wall_col;
         r_paddle_q <= paddle_col;
      end
   end

   // Match FSM; ball_reset and game_over are registered together with the state
   always_ff @(posedge game_clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_timer      <= 8'd0;
         r_points_a   <= 3'd0;
         r_points_b   <= 3'd0;
         r_ball_reset <= 1'b1;
         r_game_over  <= 1'b0;
         r_winner     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_OVER: begin
               if (w_start_ev) begin
                  r_state      <= S_SERVE;
                  r_timer      <= 8'(SERVE_TICKS - 1);
                  r_points_a   <= 3'd0;
                  r_points_b   <= 3'd0;
                  r_winner     <= 1'b0;
                  r_game_over  <= 1'b0;
                  r_ball_reset <= 1'b1;
               end
            end
            S_SERVE: begin
               if (r_timer == 8'd0) begin
                  r_state      <= S_PLAY;
                  r_ball_reset <= 1'b0;
               end else begin
                  r_timer <= r_timer - 8'd1;
               end
            end
            S_PLAY: begin
               if (w_lossa_ev | w_lossb_ev) begin
                  r_ball_reset <= 1'b1;
                  if (w_lossa_ev & ~w_lossb_ev) r_points_b <= w_b_plus;
                  if (w_lossb_ev & ~w_lossa_ev) r_points_a <= w_a_plus;
                  if (w_to_over) begin
                     r_state     <= S_OVER;
                     r_game_over <= 1'b1;
                     r_winner    <= w_lossa_ev;  // A lost the ball -> B scored
                  end else begin
                     r_state <= S_POINT;
                     r_timer <= 8'(POINT_TICKS - 1);
                  end
               end
            end
            S_POINT: begin
               if (r_timer == 8'd0) begin
                  r_state <= S_SERVE;
                  r_timer <= 8'(SERVE_TICKS - 1);
               end else begin
                  r_timer <= r_timer - 8'd1;
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_ball_reset <= 1'b1;
               r_game_over  <= 1'b0;
            end
         endcase
      end
   end

   // Sound requests: a new event always retriggers with a full duration.
   // Priority is win > point > paddle > wall.
   always_ff @(posedge game_clk or posedge reset) begin
      if (reset) begin
         r_beep_cnt  <= '0;
         r_beep_tone <= 2'd0;
      end else if (w_to_over) begin
         r_beep_cnt  <= BW'(BEEP_TICKS);
         r_beep_tone <= 2'd3;
      end else if (w_to_point) begin
         r_beep_cnt  <= BW'(BEEP_TICKS);
         r_beep_tone <= 2'd2;
      end else if (w_in_play & w_paddle_ev) begin
         r_beep_cnt  <= BW'(BEEP_TICKS);
         r_beep_tone <= 2'd1;
      end else if (w_in_play & w_wall_ev) begin
         r_beep_cnt  <= BW'(BEEP_TICKS);
         r_beep_tone <= 2'd0;
      end else if (r_beep_cnt != '0) begin
         r_beep_cnt <= r_beep_cnt - BW'(1);
      end
   end

   assign ball_reset = r_ball_reset;
   assign points_a   = r_points_a;
   assign points_b   = r_points_b;
   assign state      = r_state;
   assign game_over  = r_game_over;
   assign winner     = r_winner;
   assign beep       = (r_beep_cnt != '0);
   assign beep_tone  = r_beep_tone;

endmodule

// File: tb/tb_match_flow_controller.sv
// -----------------------------------------------------------------------------
// tb_match_flow_controller
//   Directed bench for match_flow_controller using the default parameters
//   (WIN_SCORE=5, SERVE_TICKS=120, POINT_TICKS=90, BEEP_TICKS=8). Inputs are
//   driven 1 time unit after the rising edge, and outputs are sampled at the
//   same point, so each sample shows the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_match_flow_controller;

   logic       game_clk = 1'b0;
   logic       reset;
   logic       start_btn, lossA, lossB, wall_col, paddle_col;
   logic       ball_reset, game_over, winner, beep;
   logic [2:0] points_a, points_b, state;
   logic [1:0] beep_tone;

   int n_cmp = 0;
   int n_err = 0;

   always #5 game_clk = ~game_clk;

   match_flow_controller dut (
      .game_clk  (game_clk),
      .reset     (reset),
      .start_btn (start_btn),
      .lossA     (lossA),
      .lossB     (lossB),
      .wall_col  (wall_col),
      .paddle_col(paddle_col),
      .ball_reset(ball_reset),
      .points_a  (points_a),
      .points_b  (points_b),
      .state     (state),
      .game_over (game_over),
      .winner    (winner),
      .beep      (beep),
      .beep_tone (beep_tone)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge game_clk);
      #1;
   endtask

   // Advance until the FSM reaches the target state, within a cycle budget
   task automatic wait_state(input string tag, input logic [2:0] tgt, input int budget);
      int n;
      n = 0;
      while (state !== tgt && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(state), 32'(tgt));
   endtask

   initial begin
      int cnt;
      reset = 1'b1; start_btn = 1'b0; lossA = 1'b0; lossB = 1'b0;
      wall_col = 1'b0; paddle_col = 1'b0;
      tick(); tick();

      // Reset values
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_ball_reset", 32'(ball_reset), 32'd1);
      chk("rst_points", 32'({points_a, points_b}), 32'd0);
      chk("rst_over_win", 32'({game_over, winner}), 32'd0);
      chk("rst_beep", 32'({beep, beep_tone}), 32'd0);
      reset = 1'b0;
      tick(); tick();
      chk("idle_hold", 32'(state), 32'd0);

      // Start: SERVE for exactly 120 cycles, then PLAY with ball_reset low
      start_btn = 1'b1;
      tick();
      start_btn = 1'b0;
      chk("start_serve", 32'(state), 32'd1);
      chk("serve_ball_reset", 32'(ball_reset), 32'd1);
      cnt = 1;
      while (state === 3'd1 && cnt < 300) begin
         tick();
         if (state === 3'd1) cnt++;
      end
      chk("serve_len", 32'(cnt), 32'd120);
      chk("serve_to_play", 32'(state), 32'd2);
      chk("play_ball_reset", 32'(ball_reset), 32'd0);

      // lossB held 10 cycles: exactly one point to A, point tone for 8 cycles
      lossB = 1'b1;
      tick();
      chk("lossB_pa", 32'(points_a), 32'd1);
      chk("lossB_pb", 32'(points_b), 32'd0);
      chk("lossB_state", 32'(state), 32'd3);
      chk("lossB_tone", 32'(beep_tone), 32'd2);
      chk("lossB_ball_reset", 32'(ball_reset), 32'd1);
      cnt = (beep === 1'b1) ? 1 : 0;
      for (int i = 1; i < 20; i++) begin
         if (i == 10) lossB = 1'b0;
         tick();
         if (beep === 1'b1) cnt++;
      end
      chk("point_beep_len", 32'(cnt), 32'd8);
      chk("lossB_held_once", 32'(points_a), 32'd1);
      wait_state("to_play_1", 3'd2, 400);

      // Void rally: both loss edges together
      lossA = 1'b1; lossB = 1'b1;
      tick();
      lossA = 1'b0; lossB = 1'b0;
      chk("void_scores", 32'({points_a, points_b}), 32'({3'd1, 3'd0}));
      chk("void_state", 32'(state), 32'd3);
      chk("void_tone", 32'({beep, beep_tone}), 32'({1'b1, 2'd2}));
      wait_state("to_play_2", 3'd2, 400);

      // Paddle beats wall in the same cycle
      paddle_col = 1'b1; wall_col = 1'b1;
      tick();
      paddle_col = 1'b0; wall_col = 1'b0;
      chk("pad_wall_tone", 32'({beep, beep_tone}), 32'({1'b1, 2'd1}));
      chk("pad_wall_state", 32'(state), 32'd2);
      tick(); tick();

      // Wall alone, retriggering the paddle beep
      wall_col = 1'b1;
      tick();
      wall_col = 1'b0;
      chk("wall_tone", 32'({beep, beep_tone}), 32'({1'b1, 2'd0}));

      // Bring B to 4 points
      for (int k = 0; k < 4; k++) begin
         lossA = 1'b1;
         tick();
         lossA = 1'b0;
         wait_state("to_play_b", 3'd2, 400);
      end
      chk("b_at_4", 32'({points_a, points_b}), 32'({3'd1, 3'd4}));

      // Winning point for B
      lossA = 1'b1;
      tick();
      lossA = 1'b0;
      chk("win_pb", 32'(points_b), 32'd5);
      chk("win_state", 32'(state), 32'd4);
      chk("win_over_winner", 32'({game_over, winner}), 32'({1'b1, 1'b1}));
      chk("win_tone", 32'({beep, beep_tone}), 32'({1'b1, 2'd3}));
      lossB = 1'b1;
      tick(); tick(); tick();
      lossB = 1'b0;
      chk("over_hold", 32'({state, points_a, points_b}), 32'({3'd4, 3'd1, 3'd5}));

      // Restart from OVER
      start_btn = 1'b1;
      tick();
      start_btn = 1'b0;
      chk("restart_points", 32'({points_a, points_b}), 32'd0);
      chk("restart_state", 32'(state), 32'd1);
      chk("restart_over_win", 32'({game_over, winner}), 32'd0);

      // A start edge during SERVE must not reload the serve timer
      repeat (50) tick();
      start_btn = 1'b1;
      tick();
      start_btn = 1'b0;
      repeat (69) tick();
      chk("serve_ignore_start", 32'(state), 32'd2);

      // Asynchronous reset in mid-PLAY while a beep is active
      lossB = 1'b1;
      tick();
      lossB = 1'b0;
      wait_state("to_play_3", 3'd2, 400);
      paddle_col = 1'b1;
      tick();
      paddle_col = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("async_state", 32'(state), 32'd0);
      chk("async_ball_reset", 32'(ball_reset), 32'd1);
      chk("async_points", 32'({points_a, points_b}), 32'd0);
      chk("async_beep", 32'({beep, beep_tone}), 32'd0);
      tick();
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
